// File: rtl/km_arbiter_pkg.sv
// km_arbiter_pkg: shared constants and types for the Karatsuba multiplier arbiter
package km_arbiter_pkg;
  localparam int KM_DATAWIDTH = 32;
  localparam int KM_LAT = 2;
  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;
endpackage

// File: rtl/km_arbiter_tag_pipe.sv
// km_tag_pipe: {valid,id} delay line tracking which requester owns each in-flight product
module km_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id,
  output logic any_valid
);
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] id;
  // shift tags one stage per cycle; clearing valids discards in-flight products
  always_ff @(posedge clk) begin
    if (!rstn) vld <= '0;
    else vld <= {vld[DEPTH-2:0], in_valid};
    id <= {id[DEPTH-2:0], in_id};
  end
  assign out_valid = vld[DEPTH-1];
  assign out_id = id[DEPTH-1];
  assign any_valid = |vld;
endmodule

// File: rtl/km_arbiter.sv
// km_arbiter: two-port round-robin arbiter feeding a shared pipelined Karatsuba multiplier
module km_arbiter
  import km_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = KM_DATAWIDTH,
  parameter int MUL_LAT = KM_LAT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DATAWIDTH-1:0] req0_a,
  input  logic [DATAWIDTH-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DATAWIDTH-1:0] req1_a,
  input  logic [DATAWIDTH-1:0] req1_b,
  output logic [DATAWIDTH-1:0] mul_in1,
  output logic [DATAWIDTH-1:0] mul_in2,
  input  logic [DATAWIDTH-1:0] mul_out_L,
  input  logic [DATAWIDTH-1:0] mul_out_H,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [DATAWIDTH-1:0] rsp_lo,
  output logic [DATAWIDTH-1:0] rsp_hi,
  output logic                 busy
);
  req_id_e prio, prio_nx;
  logic fire, last_valid, last_id, rsp_fire;
  logic [1:0] cnt;
  assign req0_ready = rstn && req0_valid && (!req1_valid || prio == REQ0);
  assign req1_ready = rstn && req1_valid && (!req0_valid || prio == REQ1);
  assign fire = req0_ready || req1_ready;
  assign rsp_fire = rstn && last_valid;
  assign rsp0_valid = rsp_fire && !last_id;
  assign rsp1_valid = rsp_fire && last_id;
  assign rsp_lo = mul_out_L;
  assign rsp_hi = mul_out_H;
  // priority passes to the requester that lost (or did not ask) this cycle
  always_comb prio_nx = req0_ready ? REQ1 : req1_ready ? REQ0 : prio;
  // pointer, multiplier issue register (zero when idle) and outstanding count
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio <= REQ0;
      mul_in1 <= '0;
      mul_in2 <= '0;
      cnt <= '0;
    end else begin
      prio <= prio_nx;
      mul_in1 <= req0_ready ? req0_a : req1_ready ? req1_a : '0;
      mul_in2 <= req0_ready ? req0_b : req1_ready ? req1_b : '0;
      cnt <= cnt + 2'(fire) - 2'(rsp_fire);
    end
  end
  // the pipeline can never hold more products than it has stages
  always_ff @(posedge clk) begin
    if (rstn) assert (int'(cnt) <= MUL_LAT + 1) else $error("km_arbiter: outstanding count %0d exceeds pipeline depth", cnt);
  end
  km_tag_pipe #(.DEPTH(MUL_LAT + 1)) u_tag (
    .clk(clk),
    .rstn(rstn),
    .in_valid(fire),
    .in_id(req1_ready),
    .out_valid(last_valid),
    .out_id(last_id),
    .any_valid(busy)
  );
endmodule

// File: tb/tb_km_arbiter.sv
// tb_km_arbiter: directed scoreboard bench for km_arbiter with a behavioural 2-stage multiplier
module tb_km_arbiter;
  localparam int DW = 32;
  localparam int LAT = 2;
  logic clk = 1'b0, rstn = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [DW-1:0] mul_in1, mul_in2, mul_out_L, mul_out_H, rsp_lo, rsp_hi;
  logic rsp0_valid, rsp1_valid, busy;
  logic [63:0] p1, p2;
  typedef struct {int due; logic id; logic [63:0] p;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0, g0 = 0, g1 = 0;

  km_arbiter #(.DATAWIDTH(DW), .MUL_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out_L(mul_out_L), .mul_out_H(mul_out_H),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1 <= 64'(mul_in1) * 64'(mul_in2);
    p2 <= p1;
  end
  assign mul_out_L = p2[DW-1:0];
  assign mul_out_H = p2[2*DW-1:DW];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (req0_ready) g0++;
    if (req1_ready) g1++;
    if (rsp0_valid || rsp1_valid) begin
      if (q.size() == 0) chk("spurious_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
      else begin
        e = q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
        chk("rsp_id", {62'd0, rsp1_valid, rsp0_valid}, e.id ? 64'd2 : 64'd1);
        chk("rsp_prod", {rsp_hi, rsp_lo}, e.p);
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("missing_rsp", {62'd0, rsp1_valid, rsp0_valid}, e.id ? 64'd2 : 64'd1);
    end
  end

  task automatic drive(input logic v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                       input logic e0, input logic e1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    @(negedge clk);
    chk("req0_ready", 64'(req0_ready), 64'(e0));
    chk("req1_ready", 64'(req1_ready), 64'(e1));
    if (e0) q.push_back('{cyc + LAT + 1, 1'b0, 64'(a0) * 64'(b0)});
    else if (e1) q.push_back('{cyc + LAT + 1, 1'b1, 64'(a1) * 64'(b1)});
    @(posedge clk); #1;
    chk("mul_in1", 64'(mul_in1), 64'(e0 ? a0 : e1 ? a1 : '0));
    chk("mul_in2", 64'(mul_in2), 64'(e0 ? b0 : e1 ? b1 : '0));
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    q.delete();
    @(negedge clk);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rst_mul_in1", 64'(mul_in1), 64'd0);
    chk("rst_mul_in2", 64'(mul_in2), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    do_reset(2);
    // single op
    drive(1'b1, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("busy_after_issue", 64'(busy), 64'd1);
    idle(5);
    chk("busy_idle", 64'(busy), 64'd0);
    // contention from reset: 0 then 1
    do_reset(1);
    drive(1'b1, 32'd2, 32'd7, 1'b1, 32'd4, 32'd9, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd4, 32'd9, 1'b0, 1'b1);
    idle(5);
    // max operands
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(5);
    // streaming on requester 1
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1, 32'(i), 32'(i + 1), 1'b0, 1'b1);
      chk("stream_busy", 64'(busy), 64'd1);
    end
    req1_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("drain_busy", 64'(busy), 64'd1);
    end
    idle(3);
    chk("stream_done_busy", 64'(busy), 64'd0);
    // reset mid-flight: both products discarded
    do_reset(1);
    drive(1'b1, 32'd6, 32'd7, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd8, 32'd9, 1'b0, 1'b1);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midflight_busy", 64'(busy), 64'd0);
    end
    drive(1'b1, 32'd11, 32'd12, 1'b1, 32'd13, 32'd14, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd13, 32'd14, 1'b0, 1'b1);
    idle(5);
    // fairness under sustained contention
    do_reset(1);
    g0 = 0; g1 = 0;
    for (int i = 0; i < 10; i++)
      drive(1'b1, 32'(i + 100), 32'(i + 3), 1'b1, 32'(i + 20), 32'(i + 5), (i % 2) == 0, (i % 2) == 1);
    idle(5);
    chk("fair_g0", 64'(g0), 64'd5);
    chk("fair_g1", 64'(g1), 64'd5);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/km_arbiter.md
# km_arbiter

Two-port round-robin arbiter and sequencer for the shared pipelined Karatsuba multiplier in the NTT datapath. Each butterfly unit issues (a, b) operand pairs on its own valid/ready port. The block grants at most one pair per cycle, registers it onto the multiplier inputs, and tracks a requester tag through the multiplier latency. It returns the full 2·DATAWIDTH product to the requester that issued it.

## Interface
- DATAWIDTH, default `datawidth: operand width; must be even (Karatsuba split).
- MUL_LAT, default 2: cycles from the multiplier input register to a valid out_L/out_H.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  pair accepted this cycle.
- req0_a, req0_b  in  DATAWIDTH each  operands from requester 0.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- mul_in1, mul_in2  out  DATAWIDTH each  registered operands to the multiplier.
- mul_out_L, mul_out_H  in  DATAWIDTH each  product halves from the multiplier.
- rsp0_valid  out  1  one-cycle pulse: product for requester 0 is present.
- rsp1_valid  out  1  same, for requester 1.
- rsp_lo, rsp_hi  out  DATAWIDTH each  product, shared by both responses and qualified by rspX_valid.
- busy  out  1  at least one product is in flight.

## Operation
- Fire condition: reqX_valid && reqX_ready. Ready is combinational from the valids and the priority pointer. At most one ready is high per cycle, and ready is never high without the matching valid.
- Arbitration:
  - Only one valid high: that requester is granted.
  - Both valid: the requester named by the pointer `prio` is granted.
  - After any grant, `prio` moves to the non-granted requester.
  - No grant: `prio` holds.
- Issue register: on a grant, mul_in1/mul_in2 load the granted a/b. With no grant they load 0, so the multiplier sees deterministic idle input.
- Tag pipeline: a shift register MUL_LAT+1 entries deep, each entry {valid, id}. Entry 0 is loaded on the same edge as mul_in. The last entry drives rspX_valid, where X = id.
- Responses are not backpressured. The requester must accept a result in its pulse cycle.
- rsp_lo/rsp_hi = mul_out_L/mul_out_H, passed through combinationally.
- The product is the unsigned full product: {rsp_hi, rsp_lo} = a·b mod 2^(2·DATAWIDTH).
- busy = OR of all tag valid bits.
- Outstanding counter: 2 bits, incremented on issue and decremented on response, both in the same cycle when both happen. A counter value greater than MUL_LAT+1 is a design error, checked by assertion.
- Reset (rstn low at an edge), including mid-operation:
  - all tag valids, the counter, `prio` (to requester 0), mul_in1 and mul_in2 clear;
  - in-flight products are discarded and no rsp pulse follows;
  - readies are forced low while rstn is low.

## Timing
- Reset values: req0_ready=0, req1_ready=0, mul_in1=0, mul_in2=0, rsp0_valid=0, rsp1_valid=0, busy=0. rsp_lo/rsp_hi follow the multiplier output and are don't-care when no rsp valid is high.
- Latency: a grant in cycle N gives rspX_valid high in cycle N+1+MUL_LAT, which is N+3 at default.
- Throughput: one product per cycle. Under both-valid contention the grants alternate 0,1,0,1...
- Grant and response in the same cycle are independent and both take effect.

## Structure
- Shared package/header (ntt_define.vh): `datawidth, and the default multiplier latency constant KM_LAT=2.
- One sub-module, km_tag_pipe: a parameterised {valid,id} delay line of depth MUL_LAT+1 with synchronous active-low clear.
- The multiplier itself is instantiated by the parent, not inside this block.

## Test plan
- Single op: after reset, req0 a=3, b=5 for one cycle. req0_ready is high that cycle, rsp0_valid pulses 3 cycles later with rsp_lo=15, rsp_hi=0, and rsp1_valid stays 0.
- Contention: both valid from cycle 0 with pairs (2,7) and (4,9), each held until its own ready. Requester 0 is granted first, then requester 1. rsp0 gives 14 at cycle 3 and rsp1 gives 36 at cycle 4.
- Max operands, DATAWIDTH=32: a=b=0xFFFFFFFF gives rsp_hi=0xFFFFFFFE, rsp_lo=0x00000001.
- Streaming: req1 alone, valid for 8 consecutive cycles with a=i, b=i+1. Expect 8 consecutive rsp1 pulses carrying i·(i+1) in order, with busy high throughout.
- Reset mid-flight: issue two ops, then drop rstn for one cycle on the next edge. No rsp pulse appears, busy=0, and the next contention goes to requester 0 first.
- Fairness: both valid for 10 cycles gives exactly 5 grants each, strictly alternating.
